// File: rtl/div_const_pkg.sv
// Shared constants and FSM state type for the radix-11 digit extraction path.
package div_const_pkg;

  localparam int DIVISOR    = 11;
  localparam int IN_W       = 64;
  localparam int Q_W        = 61;
  localparam int R_W        = 4;
  localparam int MAX_DIGITS = 19;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    EMIT
  } state_t;

endpackage

// File: rtl/div_64_11.sv
// Combinational 64-bit unsigned divide by 11: Q = X / 11, R = X % 11.
// Restoring long division; the top three dividend bits seed the remainder since they are < 11.
module div_64_11
  import div_const_pkg::*;
(
  input  logic [IN_W-1:0] X,
  output logic [Q_W-1:0]  Q,
  output logic [R_W-1:0]  R
);

  logic [R_W:0] rem;

  always_comb begin
    rem = {2'b00, X[IN_W-1:Q_W]};
    Q   = '0;
    for (int i = Q_W - 1; i >= 0; i--) begin
      rem = {rem[R_W-1:0], X[i]};
      if (rem >= (R_W+1)'(DIVISOR)) begin
        rem  = rem - (R_W+1)'(DIVISOR);
        Q[i] = 1'b1;
      end
    end
    R = rem[R_W-1:0];
  end

endmodule

// File: rtl/div11_digit_serializer.sv
// Streams base-11 digits of a 64-bit word LSB first; first digit 2 cycles after accept, one digit per 2 cycles.
// Digit outputs hold while dig_ready is low; in_ready is only high in IDLE (no input buffering).
module div11_digit_serializer
  import div_const_pkg::*;
#(
  parameter int MAX_DIGITS = 19,
  parameter int CNT_W      = 5,
  parameter int DIGIT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_data,
  output logic               dig_valid,
  input  logic               dig_ready,
  output logic [DIGIT_W-1:0] dig_data,
  output logic [CNT_W-1:0]   dig_idx,
  output logic               dig_last,
  output logic               busy
);

  state_t             state, state_nxt;
  logic [IN_W-1:0]    value;
  logic [Q_W-1:0]     quot;
  logic [Q_W-1:0]     div_q;
  logic [R_W-1:0]     div_r;
  logic [DIGIT_W-1:0] digit;
  logic [CNT_W-1:0]   idx;
  logic               last;
  logic               accept;
  logic               dig_hs;

  div_64_11 u_div (
    .X (value),
    .Q (div_q),
    .R (div_r)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    dig_valid = 1'b0;
    accept    = 1'b0;
    dig_hs    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid;
        if (in_valid) state_nxt = CALC;
      end
      CALC: state_nxt = EMIT;
      EMIT: begin
        dig_valid = 1'b1;
        dig_hs    = dig_ready;
        if (dig_ready) state_nxt = last ? IDLE : CALC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      value <= '0;
      quot  <= '0;
      digit <= '0;
      idx   <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        value <= in_data;
        idx   <= '0;
      end
      if (state == CALC) begin
        digit <= div_r;
        quot  <= div_q;
        last  <= (div_q == '0);
      end
      // Quotient becomes the next dividend only once the current digit is taken.
      if (dig_hs && !last) begin
        value <= {{(IN_W-Q_W){1'b0}}, quot};
        idx   <= idx + CNT_W'(1);
      end
    end
  end

  assign dig_data = digit;
  assign dig_idx  = idx;
  assign dig_last = last;

`ifndef SYNTHESIS
  a_rem_range: assert property (@(posedge clk) disable iff (rst)
    (state == CALC) |-> (div_r <= R_W'(DIVISOR - 1)));
  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    dig_valid |-> (idx < CNT_W'(MAX_DIGITS)));
`endif

endmodule

// File: tb/tb_div11_digit_serializer.sv
// Directed and random checks of the radix-11 digit serializer against an arithmetic reference.
module tb_div11_digit_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        dig_valid;
  logic        dig_ready;
  logic [3:0]  dig_data;
  logic [4:0]  dig_idx;
  logic        dig_last;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  div11_digit_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_data  (dig_data),
    .dig_idx   (dig_idx),
    .dig_last  (dig_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dig_valid();
    int w;
    w = 0;
    while (!dig_valid && w < 20) begin
      step();
      w++;
    end
    chk("dig_valid_wait", dig_valid, 1);
  endtask

  // Reference digits come from repeated x % 11, x / 11 on the input word.
  task automatic run_word(input logic [63:0] v, input bit rnd, input int stall0);
    logic [63:0]  x;
    logic [127:0] sum;
    logic [127:0] pw;
    int           exp_d[$];
    int           n, t_acc, w, st;
    x = v;
    do begin
      exp_d.push_back(int'(x % 64'd11));
      x = x / 64'd11;
    end while (x != 0);
    n = exp_d.size();

    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    chk("in_ready_before_word", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = v;
    dig_ready = rnd ? 1'b0 : 1'b1;
    t_acc     = cyc;
    step();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    chk("busy_after_accept", busy, 1);
    chk("in_ready_low_after_accept", in_ready, 0);

    sum = '0;
    pw  = 128'd1;
    for (int i = 0; i < n; i++) begin
      wait_dig_valid();
      if (i == 0) chk("first_latency", 64'(cyc - t_acc), 2);
      else if (!rnd && stall0 == 0) chk("digit_spacing", 64'(cyc - t_acc), 64'(2 * (i + 1)));
      chk("dig_data", dig_data, 64'(exp_d[i]));
      chk("dig_idx", dig_idx, 64'(i));
      chk("dig_last", dig_last, (i == n - 1));
      st = (i == 0 && stall0 > 0) ? stall0 : (rnd ? int'($urandom_range(0, 3)) : 0);
      if (st > 0) begin
        dig_ready = 1'b0;
        repeat (st) begin
          step();
          chk("hold_valid", dig_valid, 1);
          chk("hold_data", dig_data, 64'(exp_d[i]));
          chk("hold_idx", dig_idx, 64'(i));
          chk("hold_last", dig_last, (i == n - 1));
        end
      end
      sum = sum + 128'(dig_data) * pw;
      pw  = pw * 128'd11;
      dig_ready = 1'b1;
      step();
      dig_ready = rnd ? 1'b0 : 1'b1;
    end

    chk("in_ready_after_word", in_ready, 1);
    chk("dig_valid_after_word", dig_valid, 0);
    chk("busy_after_word", busy, 0);
    if (!rnd && stall0 == 0) chk("word_cycles", 64'(cyc - t_acc), 64'(2 * n + 1));
    chk("reconstruct", sum[63:0], v);
  endtask

  initial begin
    logic [63:0] rv;
    int          w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    dig_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dig_valid", dig_valid, 0);
    chk("rst_dig_data", dig_data, 0);
    chk("rst_dig_idx", dig_idx, 0);
    chk("rst_dig_last", dig_last, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    run_word(64'd0, 1'b0, 0);
    run_word(64'd10, 1'b0, 0);
    run_word(64'd1000, 1'b0, 0);
    run_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    run_word(64'd121, 1'b0, 5);

    // Abort a word while digit 1 is stalled; reset coincides with dig_ready high.
    in_valid  = 1'b1;
    in_data   = 64'd1000;
    dig_ready = 1'b1;
    step();
    in_valid = 1'b0;
    wait_dig_valid();
    chk("abort_d0", dig_data, 10);
    step();
    dig_ready = 1'b0;
    wait_dig_valid();
    chk("abort_d1_idx", dig_idx, 1);
    chk("abort_d1", dig_data, 2);
    step();
    step();
    chk("abort_hold_idx", dig_idx, 1);
    rst       = 1'b1;
    dig_ready = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_dig_valid", dig_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_dig_idx", dig_idx, 0);
    chk("abort_dig_last", dig_last, 0);
    chk("abort_dig_data", dig_data, 0);
    w = 0;
    repeat (3) begin
      step();
      if (dig_valid) w++;
    end
    chk("abort_no_stray_digits", 64'(w), 0);
    run_word(64'd11, 1'b0, 0);

    repeat (8) begin
      rv = {$urandom, $urandom};
      rv = rv >> $urandom_range(0, 63);
      run_word(rv, 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
